bfp_scale_ctrl: RTL and testbench

- Block-floating-point scaling controller for one FFT stage.
- Each beat it takes DATA_WIDTH lanes of 5-bit redundant-sign-bit counts (re and im), reduces them through a min_detect instance, and tracks a running minimum over a block of BLOCK_BEATS beats.
- At block end it publishes a clamped shift value through a valid/ready output register for the next stage's normaliser.
- Input back-pressure is applied only when a finished result cannot be stored.

---
 rtl/bfp_pkg.sv | 12 +
 rtl/min_detect.sv | 22 ++
 rtl/bfp_scale_ctrl.sv | 123 ++++++++++++
 tb/tb_bfp_scale_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point scale controller.
package bfp_pkg;
  localparam int              CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  typedef enum logic {S_IDLE, S_ACC} state_e;

  function automatic logic [CNT_W-1:0] clamp_shift(input logic [CNT_W-1:0] v,
                                                   input logic [CNT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/min_detect.sv
// Per-beat minimum of redundant-sign-bit counts across all re/im lanes.
module min_detect
  import bfp_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0][CNT_W-1:0] cnt_re_i,
  input  logic [DATA_WIDTH-1:0][CNT_W-1:0] cnt_im_i,
  output logic [CNT_W-1:0]                 min_o
);
  logic [DATA_WIDTH-1:0][CNT_W-1:0] lane_min;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    assign lane_min[g] = (cnt_re_i[g] < cnt_im_i[g]) ? cnt_re_i[g] : cnt_im_i[g];
  end

  always_comb begin
    min_o = CNT_MAX;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (lane_min[i] < min_o) min_o = lane_min[i];
  end
endmodule

// File: rtl/bfp_scale_ctrl.sv
// BFP scaling controller: running block minimum of sign-bit counts, published
// as a clamped shift through a valid/ready result register.
module bfp_scale_ctrl
  import bfp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BLOCK_BEATS = 32,
  parameter int MAX_SHIFT   = 15,
  parameter int BLK_ID_W    = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_en,
  input  logic                            i_flush,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [DATA_WIDTH-1:0][CNT_W-1:0] i_cnt_re,
  input  logic [DATA_WIDTH-1:0][CNT_W-1:0] i_cnt_im,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [CNT_W-1:0]                o_shift,
  output logic [CNT_W-1:0]                o_raw_min,
  output logic [BLK_ID_W-1:0]             o_blk_id,
  output logic                            o_busy
);
  localparam int               BW      = $clog2(BLOCK_BEATS);
  localparam logic [BW-1:0]    LAST    = BW'(BLOCK_BEATS - 1);
  localparam logic [CNT_W-1:0] MAX_SH  = CNT_W'(MAX_SHIFT);

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [CNT_W-1:0]     run_min_q, run_min_d;
  logic [BLK_ID_W-1:0]  blk_q, blk_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]     raw_q, raw_d;
  logic [BLK_ID_W-1:0]  id_q, id_d;

  logic [CNT_W-1:0] bm, nm;
  logic             last, take;

  min_detect #(.DATA_WIDTH(DATA_WIDTH)) u_min (
    .cnt_re_i (i_cnt_re),
    .cnt_im_i (i_cnt_im),
    .min_o    (bm)
  );

  assign nm   = (bm < run_min_q) ? bm : run_min_q;
  assign last = (beat_q == LAST);
  // Stall only the last beat, and only when the held result cannot drain now.
  assign o_ready = (state_q == S_ACC) && !i_flush && !(last && valid_q && !i_ready);
  assign take    = i_valid && o_ready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    run_min_d = run_min_q;
    blk_d     = blk_q;
    shift_d   = shift_q;
    raw_d     = raw_q;
    id_d      = id_q;
    valid_d   = valid_q && !i_ready;
    if (i_flush) begin
      state_d   = S_IDLE;
      beat_d    = '0;
      run_min_d = CNT_MAX;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_en) begin
            state_d   = S_ACC;
            beat_d    = '0;
            run_min_d = CNT_MAX;
          end
        end
        S_ACC: begin
          if (take && last) begin
            raw_d     = nm;
            shift_d   = clamp_shift(nm, MAX_SH);
            id_d      = blk_q;
            blk_d     = blk_q + 1'b1;
            valid_d   = 1'b1;
            beat_d    = '0;
            run_min_d = CNT_MAX;
            state_d   = i_en ? S_ACC : S_IDLE;
          end else if (take) begin
            run_min_d = nm;
            beat_d    = beat_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      run_min_q <= CNT_MAX;
      blk_q     <= '0;
      valid_q   <= 1'b0;
      shift_q   <= '0;
      raw_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      run_min_q <= run_min_d;
      blk_q     <= blk_d;
      valid_q   <= valid_d;
      shift_q   <= shift_d;
      raw_q     <= raw_d;
      id_q      <= id_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_shift   = shift_q;
  assign o_raw_min = raw_q;
  assign o_blk_id  = id_q;
  assign o_busy    = (state_q == S_ACC);
endmodule

// File: tb/tb_bfp_scale_ctrl.sv
// Directed plus randomized bench for bfp_scale_ctrl against a block-level model.
module tb_bfp_scale_ctrl;
  localparam int DW = 16;
  localparam int BB = 4;
  localparam int MS = 15;
  localparam int IW = 8;

  typedef logic [DW-1:0][4:0] lanes_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_en = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  lanes_t        i_cnt_re = '1, i_cnt_im = '1;
  logic          o_ready, o_valid, o_busy;
  logic [4:0]    o_shift, o_raw_min;
  logic [IW-1:0] o_blk_id;

  int checks = 0;
  int failures = 0;

  // Block-level model: whether a block is open, beats seen, min so far, result.
  bit m_active;
  int m_beats, m_min, m_blk;
  bit m_valid;
  int m_shift, m_raw, m_id;

  bfp_scale_ctrl #(.DATA_WIDTH(DW), .BLOCK_BEATS(BB), .MAX_SHIFT(MS), .BLK_ID_W(IW)) dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_cnt_re(i_cnt_re), .i_cnt_im(i_cnt_im), .o_valid(o_valid),
    .i_ready(i_ready), .o_shift(o_shift), .o_raw_min(o_raw_min), .o_blk_id(o_blk_id),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic lanes_t fill(input int v);
    lanes_t a;
    for (int i = 0; i < DW; i++) a[i] = 5'(v);
    return a;
  endfunction

  function automatic int beat_min(input lanes_t re, input lanes_t im);
    int m = 31;
    for (int i = 0; i < DW; i++) begin
      if (int'(re[i]) < m) m = int'(re[i]);
      if (int'(im[i]) < m) m = int'(im[i]);
    end
    return m;
  endfunction

  task automatic model_reset();
    m_active = 0; m_beats = 0; m_min = 31; m_blk = 0;
    m_valid = 0; m_shift = 0; m_raw = 0; m_id = 0;
  endtask

  task automatic check_outs();
    chk("o_valid", o_valid, m_valid);
    chk("o_shift", o_shift, m_shift);
    chk("o_raw_min", o_raw_min, m_raw);
    chk("o_blk_id", o_blk_id, m_id);
    chk("o_busy", o_busy, m_active);
  endtask

  // One clock: drive, check ready, advance model across the edge, check outputs.
  task automatic step(input bit en, input bit fl, input bit vl, input bit rd,
                      input lanes_t re, input lanes_t im);
    bit exp_ready, take, drain;
    int nm;
    i_en = en; i_flush = fl; i_valid = vl; i_ready = rd;
    i_cnt_re = re; i_cnt_im = im;
    #1;
    exp_ready = m_active && !fl && !(m_beats == BB-1 && m_valid && !rd);
    chk("o_ready", o_ready, exp_ready);
    take  = vl && exp_ready;
    drain = m_valid && rd;
    @(posedge clk);
    #1;
    if (drain) m_valid = 0;
    if (fl) begin
      m_active = 0; m_beats = 0; m_min = 31;
    end else if (!m_active) begin
      if (en) begin m_active = 1; m_beats = 0; m_min = 31; end
    end else if (take) begin
      nm = beat_min(re, im);
      if (m_min < nm) nm = m_min;
      if (m_beats == BB-1) begin
        m_raw = nm; m_shift = (nm > MS) ? MS : nm; m_id = m_blk;
        m_blk = (m_blk + 1) % (1 << IW); m_valid = 1;
        m_beats = 0; m_min = 31; m_active = en;
      end else begin
        m_min = nm; m_beats++;
      end
    end
    check_outs();
  endtask

  task automatic reset_pulse();
    i_valid = 0; i_flush = 0;
    #2 rstn = 0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_shift", o_shift, 0);
    chk("rst_o_raw", o_raw_min, 0);
    chk("rst_o_blk_id", o_blk_id, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_o_ready", o_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
  endtask

  initial begin
    lanes_t a, b, ten;
    int base;
    model_reset();
    ten = fill(10);
    #3; check_outs();
    @(posedge clk); #1; rstn = 1;

    // 1: min of 3 on beat 2 re lane 7
    step(1, 0, 0, 1, ten, ten);
    for (int k = 0; k < BB; k++) begin
      a = ten;
      if (k == 2) a[7] = 5'd3;
      step(1, 0, 1, 1, a, ten);
    end
    chk("t1_valid", o_valid, 1); chk("t1_raw", o_raw_min, 3);
    chk("t1_shift", o_shift, 3); chk("t1_id", o_blk_id, 0);

    // 2: min 20 on imag lane 15 clamps to 15
    for (int k = 0; k < BB; k++) begin
      a = fill(25); b = fill(25);
      if (k == 1) b[15] = 5'd20;
      step(1, 0, 1, 1, a, b);
    end
    chk("t2_raw", o_raw_min, 20); chk("t2_shift", o_shift, 15); chk("t2_id", o_blk_id, 1);

    // 3: back-to-back blocks with consumer stalled
    reset_pulse();
    step(1, 0, 0, 0, ten, ten);
    for (int k = 0; k < 2*BB - 1; k++) step(1, 0, 1, 0, fill(12 + k), ten);
    chk("t3_id_before", o_blk_id, 0);
    step(1, 0, 1, 0, fill(5), ten);
    step(1, 0, 1, 0, fill(5), ten);
    chk("t3_stalled_valid", o_valid, 1);
    step(1, 0, 1, 1, fill(5), ten);
    chk("t3_valid_kept", o_valid, 1); chk("t3_id_after", o_blk_id, 1);
    chk("t3_raw", o_raw_min, 5);

    // 4: flush on beat 2, then a fresh block with min 7
    step(1, 0, 0, 1, ten, ten);
    step(1, 0, 1, 1, fill(2), ten);
    step(1, 0, 1, 1, fill(2), ten);
    step(1, 1, 1, 1, fill(1), ten);
    step(1, 0, 0, 1, ten, ten);
    for (int k = 0; k < BB; k++) step(1, 0, 1, 1, fill(k == 3 ? 7 : 12), fill(9));
    chk("t4_raw", o_raw_min, 7); chk("t4_id", o_blk_id, 2);

    // 5: i_en dropped at beat 1, block still completes then idles
    step(1, 0, 1, 1, fill(20), fill(20));
    for (int k = 1; k < BB; k++) step(0, 0, 1, 1, fill(20), fill(18));
    chk("t5_raw", o_raw_min, 18); chk("t5_busy", o_busy, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, fill(4), fill(4));
    chk("t5_idle_ready", o_ready, 0);

    // 6: async reset mid-block while a result is held
    step(1, 0, 0, 0, ten, ten);
    for (int k = 0; k < BB + 2; k++) step(1, 0, 1, 0, fill(11), ten);
    chk("t6_pre_valid", o_valid, 1);
    reset_pulse();
    step(1, 0, 0, 1, ten, ten);
    for (int k = 0; k < BB; k++) step(1, 0, 1, 1, fill(14), fill(16));
    chk("t6_id", o_blk_id, 0); chk("t6_raw", o_raw_min, 14);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      base = $urandom_range(0, 28);
      for (int i = 0; i < DW; i++) begin
        a[i] = 5'(base + $urandom_range(0, 31 - base));
        b[i] = 5'(base + $urandom_range(0, 31 - base));
      end
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 6), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
